// File: rtl/hazard_scheduler_pkg.sv
// rtl/hazard_scheduler_pkg.sv - shared control types and constants for the pipeline hazard scheduler
package hazard_scheduler_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] X0_IDX = 5'd0;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MD_WAIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator between ID operands and EX load
module load_use_detect
    import hazard_scheduler_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_load && (ex_rd != X0_IDX) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - stall/flush sequencer: reset fill, load-use stalls, branch flushes, mul/div waits
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int FILL_CYCLES = 3,
    parameter int MD_TIMEOUT  = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_md_op,
    input  logic             md_done,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exmem_bubble,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int FW = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES + 1) : 1;
    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);
    localparam logic [TW-1:0] MD_LAST   = TW'(MD_TIMEOUT - 1);

    sched_state_t  state, state_nx;
    logic [FW-1:0] fill_cnt;
    logic [TW-1:0] md_cnt;
    logic          load_use;
    logic          md_timeout;

    load_use_detect u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_load    (ex_load),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    // Controls are gated by rst so the pipeline sees no action while reset is held
    always_comb begin
        state_nx     = state;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_start     = 1'b0;
        md_timeout   = 1'b0;
        if (!rst) begin
            case (state)
                ST_FILL: begin
                    idex_bubble = 1'b1;
                    if (fill_cnt == FILL_LAST) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (ex_md_op) begin
                        md_start     = 1'b1;
                        pc_hold      = 1'b1;
                        ifid_hold    = 1'b1;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                        state_nx     = ST_MD_WAIT;
                    end else if (load_use) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        state_nx = ST_RUN;
                    end else if (md_cnt == MD_LAST) begin
                        // Give up: drop the stalled op so the pipeline keeps moving
                        md_timeout   = 1'b1;
                        exmem_bubble = 1'b1;
                        state_nx     = ST_RUN;
                    end else begin
                        pc_hold      = 1'b1;
                        ifid_hold    = 1'b1;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                    end
                end
                default: state_nx = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FILL;
            fill_cnt    <= '0;
            md_cnt      <= '0;
            md_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_FILL && fill_cnt != FILL_LAST) fill_cnt <= fill_cnt + 1'b1;
            if (state == ST_RUN) md_cnt <= '0;
            else if (state == ST_MD_WAIT && !md_done && !md_timeout) md_cnt <= md_cnt + 1'b1;
            if (md_timeout) md_error <= 1'b1;
            if (pc_hold && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Takes decode-stage operand usage, EX-stage load/branch/multi-cycle status and the multiply-divide unit's done handshake.
- Drives hold, bubble and flush controls on the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Owns the post-reset pipeline fill, load-use stalls, taken-branch flushes and multi-cycle mul/div waits, plus a stall performance counter.

Parameters:
- FILL_CYCLES, 3, cycles of forced ID/EX bubbles after reset.
- MD_TIMEOUT, 64, maximum cycles waiting for md_done before abort.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  the ID instruction reads rs1.
- id_use_rs2  in  1  the ID instruction reads rs2.
- ex_load  in  1  the EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  the EX branch/jump resolved taken.
- ex_md_op  in  1  the EX instruction is multi-cycle mul/div.
- md_done  in  1  mul/div result valid this cycle.
- pc_hold  out  1  PC does not update.
- ifid_hold  out  1  IF/ID keeps its contents.
- idex_hold  out  1  ID/EX keeps its contents.
- idex_bubble  out  1  ID/EX loads a NOP.
- ifid_flush  out  1  IF/ID loads a NOP.
- exmem_bubble  out  1  EX/MEM loads a NOP.
- md_start  out  1  one-cycle start pulse to the mul/div unit.
- md_error  out  1  sticky timeout flag.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: all control outputs are 0 while rst=1. State goes to FILL with fill counter 0. stall_count, md_error and the timeout counter clear to 0.
- Control outputs are combinational from state and inputs. State and counters are registered.
- Definition: load_use = ex_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- FILL state:
  - idex_bubble=1 every cycle.
  - After FILL_CYCLES cycles, move to RUN.
  - All other inputs are ignored.
- RUN state, priorities in order:
  1. ex_branch_taken: ifid_flush=1 and idex_bubble=1 in the same cycle. No hold. load_use and ex_md_op are ignored.
  2. ex_md_op: md_start=1; pc_hold, ifid_hold, idex_hold and exmem_bubble all =1. Next state is MD_WAIT with the timeout counter cleared.
  3. load_use: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly this cycle. The next cycle re-evaluates, with the load now in MEM.
  4. Otherwise: all controls are 0.
- MD_WAIT state:
  - While md_done=0: pc_hold, ifid_hold, idex_hold and exmem_bubble =1. The timeout counter increments. md_start=0.
  - md_done=1: all holds and bubbles are 0 so the result enters EX/MEM; go to RUN.
  - md_done arriving in the same cycle as md_start (RUN) is ignored. The unit may not complete in 0 cycles.
  - Counter reaching MD_TIMEOUT-1 with md_done=0: md_error set (sticky until rst), exmem_bubble=1, holds released, go to RUN.
- stall_count:
  - Increments on every cycle where pc_hold=1.
  - Saturates at all-ones.
  - Branch-flush cycles are not counted.
- rst asserted mid-MD_WAIT or mid-stall: on the next edge, state is FILL and md_start is not reissued.
- md_done is ignored in FILL and RUN.

Decomposition:
- Shared control package holds:
  - the state encoding: FILL=2'd0, RUN=2'd1, MD_WAIT=2'd2;
  - the register-index width constant (5);
  - the x0 index constant.
- One sub-module, load_use_detect: purely combinational comparator producing load_use. Reused by the forwarding unit.

Test Plan:
- Reset release, idle inputs -> idex_bubble=1 for exactly 3 cycles, then all controls 0 and stall_count=0.
- ex_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle with pc_hold=ifid_hold=idex_bubble=1, stall_count=1. Repeat with ex_rd=0 -> no stall.
- Load-use condition plus ex_branch_taken=1 in the same cycle -> ifid_flush=idex_bubble=1, pc_hold=0, stall_count unchanged.
- ex_md_op=1, md_done=1 four cycles later -> md_start for 1 cycle; holds and exmem_bubble high for 4 cycles total, 0 on the done cycle; stall_count=4.
- ex_md_op=1, md_done never -> after 64 cycles md_error=1, holds drop, state RUN; md_error stays 1 until rst.
- rst=1 during MD_WAIT, then release -> 3 fill cycles, md_error=0, no md_start pulse.
